// File: rtl/digit_scan_pkg.sv
// Shared types, defaults and the board select-code mapping for the digit scan driver.
package digit_scan_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_ZERO = 4'd0;

  localparam int DEF_NUM_DIGITS = 4;
  localparam int DEF_DIV        = 1000;
  localparam int DEF_GUARD      = 2;
  localparam int DEF_SEL_W      = 3;
  localparam int DEF_SEL_SKIP   = 2;

  // The board has no digit wired at code SEL_SKIP (colon), so later slots shift up by one.
  function automatic int unsigned sel_code(input int unsigned idx, input int unsigned skip);
    return (idx >= skip) ? idx + 1 : idx;
  endfunction

endpackage

// File: rtl/digit_scan_prescaler.sv
// Slot prescaler: counts 0..DIV-1, flags the last cycle of a slot and the guard window of the next cycle.
module digit_scan_prescaler
  import digit_scan_pkg::*;
#(
  parameter int DIV   = DEF_DIV,
  parameter int GUARD = DEF_GUARD,
  parameter int PRE_W = $clog2(DIV)
) (
  input  logic             clk,
  input  logic             reset,
  output logic             o_tick,
  output logic [PRE_W-1:0] o_pre_nxt,
  output logic             o_guard_nxt
);

  localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] r_pre;

  assign o_tick      = (r_pre == LAST_PRE);
  assign o_pre_nxt   = o_tick ? '0 : r_pre + 1'b1;
  assign o_guard_nxt = (o_pre_nxt < PRE_W'(GUARD));

  always_ff @(posedge clk) begin
    if (reset) r_pre <= '0;
    else       r_pre <= o_pre_nxt;
  end

endmodule

// File: rtl/digit_scan_driver.sv
// Time-multiplexed N-digit 7-segment scan driver with load/ack handshake and leading-zero blanking.
// Optional macro DIGIT_SCAN_BRIGHT_EN adds a 4-bit brightness input that shortens the lit window.
module digit_scan_driver
  import digit_scan_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int DIV        = DEF_DIV,
  parameter int GUARD      = DEF_GUARD,
  parameter int SEL_W      = DEF_SEL_W,
  parameter int SEL_SKIP   = DEF_SEL_SKIP
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  output logic                    load_ack,
  input  logic                    blank_lz,
`ifdef DIGIT_SCAN_BRIGHT_EN
  input  logic [3:0]              brightness,
`endif
  output logic [SEL_W-1:0]        digit_select,
  output bcd_t                    digit_value,
  output logic                    seg_en,
  output logic                    frame_done
);

  localparam int PRE_W = $clog2(DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(DIV - 1);

  logic                    w_tick;
  logic                    w_guard_nxt;
  logic [PRE_W-1:0]        w_pre_nxt;
  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic [4*NUM_DIGITS-1:0] r_disp;
  logic [4*NUM_DIGITS-1:0] r_pend;
  logic [4*NUM_DIGITS-1:0] w_disp_nxt;
  logic                    r_pend_v;
  logic                    w_bound;
  logic                    w_dim_ok;
  bcd_t                    w_dig [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   w_lzb;

  digit_scan_prescaler #(
    .DIV   (DIV),
    .GUARD (GUARD),
    .PRE_W (PRE_W)
  ) u_pre (
    .clk         (clk),
    .reset       (reset),
    .o_tick      (w_tick),
    .o_pre_nxt   (w_pre_nxt),
    .o_guard_nxt (w_guard_nxt)
  );

  // A load coinciding with the frame boundary bypasses pend and wins over an older pending value.
  always_comb begin
    w_bound    = w_tick && (r_idx == LAST_IDX);
    w_idx_nxt  = r_idx;
    w_disp_nxt = r_disp;
    if (w_tick) w_idx_nxt = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
    if (w_bound) begin
      if (load)          w_disp_nxt = digits_in;
      else if (r_pend_v) w_disp_nxt = r_pend;
    end
  end

  always_comb begin : blanking
    logic w_zrun;
    w_zrun = blank_lz;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_dig[i] = w_disp_nxt[4*(NUM_DIGITS-1-i) +: 4];
      w_zrun   = w_zrun && (w_dig[i] == BCD_ZERO);
      w_lzb[i] = w_zrun && (i != NUM_DIGITS - 1);
    end
  end

`ifdef DIGIT_SCAN_BRIGHT_EN
  logic [3:0] r_bright;
  logic [3:0] w_bright_nxt;

  always_comb begin
    w_bright_nxt = w_bound ? brightness : r_bright;
    w_dim_ok     = (int'(w_pre_nxt) - GUARD) < (((DIV - GUARD) * int'(w_bright_nxt)) / 16);
  end

  always_ff @(posedge clk) begin
    if (reset) r_bright <= 4'hF;
    else       r_bright <= w_bright_nxt;
  end
`else
  assign w_dim_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx    <= '0;
      r_disp   <= '0;
      r_pend_v <= 1'b0;
    end else begin
      r_idx  <= w_idx_nxt;
      r_disp <= w_disp_nxt;
      if (w_bound)   r_pend_v <= 1'b0;
      else if (load) r_pend_v <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (load && !w_bound) r_pend <= digits_in;
  end

  // Outputs are computed from next-state so each registered value matches the idx/pre it is shown with.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit_select <= SEL_W'(sel_code(0, SEL_SKIP));
      digit_value  <= BCD_ZERO;
      seg_en       <= 1'b0;
      load_ack     <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      digit_select <= SEL_W'(sel_code(int'(w_idx_nxt), SEL_SKIP));
      digit_value  <= w_dig[w_idx_nxt];
      seg_en       <= !w_guard_nxt && !w_lzb[w_idx_nxt] && w_dim_ok;
      load_ack     <= w_bound && (load || r_pend_v);
      frame_done   <= (w_pre_nxt == LAST_PRE) && (w_idx_nxt == LAST_IDX);
    end
  end

endmodule
